hamming_link_sequencer: RTL and testbench

Single-clock controller that sequences the Hamming(15,11) transmit datapath: the 11-bit serial-in shifter, the combinational encoder and the 15-bit serial-out shifter. It uses one system clock with valid/ready handshakes instead of the two divided clocks. The block counts in K data bits, issues a one-cycle load into the codeword shifter, and paces N output bits. A complete next word waits in the input shifter, so codewords are emitted back-to-back.

---
 rtl/hamming_pkg.sv | 18 +
 rtl/hamming_mod_counter.sv | 32 +++
 rtl/hamming_link_sequencer.sv | 102 ++++++++++
 tb/tb_hamming_link_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, sequencer state encoding and counter sizing for the Hamming(15,11) transmit path.
// Pure declarations: no logic, no latency.
package hamming_pkg;

    localparam int K_DATA = 11;
    localparam int N_CODE = 15;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } seq_state_t;

    // A modulus of 1 or 2 still needs one bit of count.
    function automatic int cnt_w(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/hamming_mod_counter.sv
// Modulo-MOD event counter with synchronous clear; clear wins over increment.
// Latency: count updates on the edge after inc; last is combinational (inc at MOD-1).
// Backpressure: none, the caller gates inc.
module hamming_mod_counter
    import hamming_pkg::*;
#(
    parameter int MOD = K_DATA,
    parameter int W   = cnt_w(MOD)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    assign last = inc & (count == TOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/hamming_link_sequencer.sv
// Sequences serial-in shifter, encoder load and serial-out shifter for Hamming(15,11) on one clock.
// Latency: last data bit at edge t -> load in cycle t+1 -> frame_start in cycle t+2.
// Backpressure: out_ready low holds the frame; a pending full word holds in_ready low until load.
module hamming_link_sequencer
    import hamming_pkg::*;
#(
    parameter int K       = K_DATA,
    parameter int N       = N_CODE,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               shift_in_en,
    output logic               load,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               shift_out_en,
    output logic               frame_start,
    output logic               frame_end,
    output logic               busy,
    output logic [COUNT_W-1:0] frame_count
);

    localparam int IW = cnt_w(K);
    localparam int OW = cnt_w(N);
    localparam logic [OW-1:0] OUT_TOP = OW'(N - 1);
    localparam logic S_IDLE = IDLE;
    localparam logic S_EMIT = EMIT;

    logic          state;
    logic          in_full;
    logic [IW-1:0] in_cnt;
    logic [OW-1:0] out_cnt;
    logic          in_last;
    logic          out_last;
    logic          emitting;

    assign emitting = (state == S_EMIT);

    // reset is folded in so in_ready drops the moment reset asserts, not at the next edge.
    assign in_ready     = reset & enable & ~abort & ~in_full;
    assign shift_in_en  = in_ready & in_valid;
    assign out_valid    = enable & emitting;
    assign shift_out_en = out_valid & out_ready & ~abort;
    assign frame_start  = out_valid & (out_cnt == '0);
    assign frame_end    = out_valid & (out_cnt == OUT_TOP);

    // Reloading on the final accepted bit keeps frames back-to-back.
    assign load = enable & ~abort & in_full & (~emitting | out_last);
    assign busy = (in_cnt != '0) | in_full | emitting;

    hamming_mod_counter #(.MOD(K), .W(IW)) u_in_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (abort),
        .inc   (shift_in_en),
        .count (in_cnt),
        .last  (in_last)
    );

    hamming_mod_counter #(.MOD(N), .W(OW)) u_out_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (abort | load),
        .inc   (shift_out_en),
        .count (out_cnt),
        .last  (out_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            in_full     <= 1'b0;
            frame_count <= '0;
        end else if (abort) begin
            state       <= S_IDLE;
            in_full     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (in_last) begin
                in_full <= 1'b1;
            end else if (load) begin
                in_full <= 1'b0;
            end

            if (load) begin
                state <= S_EMIT;
            end else if (out_last) begin
                state <= S_IDLE;
            end

            if (out_last) begin
                frame_count <= frame_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_link_sequencer.sv
// Scoreboarded bench: directed scenarios push expected load/frame_start/frame_end events, a monitor pops them.
module tb_hamming_link_sequencer;

    localparam int CW   = 4;
    localparam int K_FE = 0;
    localparam int K_LD = 1;
    localparam int K_FS = 2;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic          shift_in_en;
    logic          load;
    logic          out_valid;
    logic          out_ready;
    logic          shift_out_en;
    logic          frame_start;
    logic          frame_end;
    logic          busy;
    logic [CW-1:0] frame_count;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    int  exp_fc = 0;
    int  base = 0;

    hamming_link_sequencer #(.K(11), .N(15), .COUNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .shift_in_en  (shift_in_en),
        .load         (load),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .shift_out_en (shift_out_en),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .busy         (busy),
        .frame_count  (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    function automatic int strobes();
        return int'({in_ready, out_valid, shift_in_en, shift_out_en, load, frame_start, frame_end});
    endfunction

    function automatic void push(input int kind, input int c, input int v);
        exp_q.push_back('{kind, c, v});
    endfunction

    function automatic void push_fe(input int c);
        push(K_FE, c, exp_fc);
        exp_fc = (exp_fc + 1) % (1 << CW);
    endfunction

    function automatic void pop_chk(input int kind, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s unexpected: got event at cycle %0d, expected none", name, cyc);
        end else begin
            e = exp_q.pop_front();
            chk({name, " kind"}, kind, e.kind);
            chk({name, " cycle"}, cyc, e.cyc);
            if (kind == K_FE) chk("frame_count at frame_end", int'(frame_count), e.val);
        end
    endfunction

    // Monitor: same-cycle events are checked in the order frame_end, load, frame_start.
    always @(negedge clk) begin
        if (frame_end && shift_out_en) pop_chk(K_FE, "frame_end");
        if (load)                      pop_chk(K_LD, "load");
        if (frame_start && shift_out_en) pop_chk(K_FS, "frame_start");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic end_test(input string name);
        chk({name, " leftover events"}, exp_q.size(), 0);
        exp_q.delete();
        chk({name, " frame_count"}, int'(frame_count), exp_fc);
    endtask

    initial begin
        int idle;
        int ov;
        int rdy;

        reset     = 1'b0;
        enable    = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset strobes", strobes(), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_count", int'(frame_count), 0);

        // Reset release with continuous traffic: 5 back-to-back frames.
        step();
        reset = 1'b1;
        base  = cyc;
        push(K_LD, base + 11, 0);
        for (int i = 0; i < 5; i++) begin
            push(K_FS, base + 12 + 15 * i, 0);
            push_fe(base + 26 + 15 * i);
            if (i < 4) push(K_LD, base + 26 + 15 * i, 0);
        end
        idle = 0;
        ov   = 0;
        for (int c = 0; c <= 90; c++) begin
            if (c > 0) step();
            in_valid = (c < 68);
            @(negedge clk);
            if (c >= 12 && c <= 67 && !in_ready) idle++;
            if (c >= 12 && c <= 86 && out_valid) ov++;
        end
        chk("idle in_ready cycles", idle, 12);
        chk("out_valid cycles over 5 frames", ov, 75);
        chk("busy after traffic", int'(busy), 0);
        end_test("continuous");

        // Output backpressure alternating mid-frame.
        step();
        base = cyc;
        push(K_LD, base + 11, 0);
        push(K_FS, base + 12, 0);
        push_fe(base + 40);
        push(K_LD, base + 40, 0);
        push(K_FS, base + 41, 0);
        push_fe(base + 55);
        rdy = 0;
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) step();
            in_valid  = (c <= 22);
            out_ready = (c >= 12 && c <= 40) ? ((c - 12) % 2 == 0) : 1'b1;
            @(negedge clk);
            if (c >= 23 && c <= 40 && in_ready) rdy++;
        end
        chk("in_ready while word pending", rdy, 0);
        end_test("backpressure");

        // Freeze with enable=0 at in_cnt=6, out_cnt=9.
        step();
        base = cyc;
        push(K_LD, base + 11, 0);
        push(K_FS, base + 12, 0);
        push_fe(base + 29);
        push(K_LD, base + 29, 0);
        push(K_FS, base + 30, 0);
        push_fe(base + 44);
        for (int c = 0; c <= 50; c++) begin
            if (c > 0) step();
            in_valid = (c <= 11) || (c >= 15 && c <= 28);
            enable   = !(c >= 21 && c <= 23);
            @(negedge clk);
            if (c >= 21 && c <= 23) begin
                chk("enable=0 strobes", strobes(), 0);
                chk("enable=0 busy", int'(busy), 1);
            end
        end
        enable = 1'b1;
        end_test("enable freeze");

        // Asynchronous reset in the middle of a cycle at in_cnt=4.
        step();
        base      = cyc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) step();
            @(negedge clk);
        end
        chk("busy before async reset", int'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset strobes", strobes(), 0);
        chk("async reset busy", int'(busy), 0);
        chk("async reset frame_count", int'(frame_count), 0);
        exp_fc = 0;
        exp_q.delete();

        // Fresh word after release, then abort at out_cnt=7 with a word pending.
        step();
        step();
        reset = 1'b1;
        base  = cyc;
        push(K_LD, base + 11, 0);
        push(K_FS, base + 16, 0);
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) step();
            in_valid  = (c <= 22);
            out_ready = !(c >= 12 && c <= 15);
            abort     = (c == 23);
            @(negedge clk);
            if (c == 23) begin
                chk("busy before abort", int'(busy), 1);
                chk("abort gates in_ready/load/shift_out_en", int'({in_ready, load, shift_out_en}), 0);
            end
            if (c == 24) begin
                chk("busy after abort", int'(busy), 0);
                chk("out_valid after abort", int'(out_valid), 0);
                chk("frame_count after abort", int'(frame_count), exp_fc);
            end
        end
        abort = 1'b0;
        end_test("abort");

        // 2^CW contiguous frames wrap frame_count back to its start.
        step();
        base = cyc;
        push(K_LD, base + 11, 0);
        for (int i = 0; i < 16; i++) begin
            push(K_FS, base + 12 + 15 * i, 0);
            push_fe(base + 26 + 15 * i);
            if (i < 15) push(K_LD, base + 26 + 15 * i, 0);
        end
        for (int c = 0; c <= 256; c++) begin
            if (c > 0) step();
            in_valid = (c <= 232);
            @(negedge clk);
        end
        chk("frame_count wrapped", int'(frame_count), 0);
        end_test("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
